// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg: shared FSM encoding and LFSR constants for lfsr_word_ctrl
package lfsr_ctrl_pkg;
    localparam int LFSR_W = 4;
    localparam logic [LFSR_W-1:0] SAFE_SEED = 4'b0001;
    typedef enum logic [2:0] {IDLE, LOAD, GEN, PRESENT, FINISH} state_t;
endpackage

// File: rtl/lfsr_word_shifter.sv
// lfsr_word_shifter: collects serial LFSR bits into a WORD_W word, first bit ends as MSB
//   clk_i/rst_i : clock, async active-high reset
//   clr_i       : restart the bit counter
//   en_i        : shift in bit_i this cycle
//   word_o      : word including the bit currently on bit_i
//   last_o      : the current bit is the final bit of the word
module lfsr_word_shifter
    import lfsr_ctrl_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              bit_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_o
);
    localparam int BW = $clog2(WORD_W);
    logic [WORD_W-2:0] shift_q;
    logic [BW-1:0]     cnt_q, cnt_d;
    assign word_o = {shift_q, bit_i};
    assign last_o = cnt_q == BW'(WORD_W - 1);
    always_comb cnt_d = clr_i ? '0 : en_i ? (last_o ? '0 : cnt_q + 1'b1) : cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (en_i) shift_q <= word_o[WORD_W-2:0];
        end
    end
endmodule

// File: rtl/lfsr_word_ctrl.sv
// lfsr_word_ctrl: sequences an external 4-bit LFSR into NUM_WORDS words over valid/ready
//   CLK/RST                  : clock, async active-high reset
//   START/ABORT/SEED/NUM_WORDS: run control, sampled in IDLE
//   BUSY/DONE                : run status (DONE pulses on normal completion)
//   WORD_OUT/VALID/READY     : word handshake to the consumer
//   LFSR_SEED/LOAD/NEXT/BIT  : external LFSR interface
//   Macro LFSR_ZERO_SEED_GUARD_EN: substitute SAFE_SEED for an all-zero seed
module lfsr_word_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [LFSR_W-1:0] SEED,
    input  logic [CNT_W-1:0]  NUM_WORDS,
    output logic              BUSY,
    output logic              DONE,
    output logic [WORD_W-1:0] WORD_OUT,
    output logic              WORD_VALID,
    input  logic              WORD_READY,
    output logic [LFSR_W-1:0] LFSR_SEED,
    output logic              LFSR_LOAD,
    output logic              LFSR_NEXT,
    input  logic              LFSR_BIT
);
    state_t            state_q, state_d;
    logic [LFSR_W-1:0] seed_q, seed_d, seed_in;
    logic [CNT_W-1:0]  left_q, left_d;
    logic [WORD_W-1:0] word_q, word_d, word_nxt;
    logic              last;
`ifdef LFSR_ZERO_SEED_GUARD_EN
    assign seed_in = (SEED == '0) ? SAFE_SEED : SEED;
`else
    assign seed_in = SEED;
`endif
    lfsr_word_shifter #(.WORD_W(WORD_W)) u_shifter (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (state_q == LOAD),
        .en_i  (state_q == GEN),
        .bit_i (LFSR_BIT),
        .word_o(word_nxt),
        .last_o(last)
    );
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        left_d  = left_q;
        word_d  = word_q;
        case (state_q)
            IDLE: if (START) begin
                state_d = (NUM_WORDS != '0) ? LOAD : FINISH;
                if (NUM_WORDS != '0) begin
                    seed_d = seed_in;
                    left_d = NUM_WORDS;
                end
            end
            LOAD: state_d = GEN;
            GEN: if (last) begin
                state_d = PRESENT;
                word_d  = word_nxt;
            end
            PRESENT: if (WORD_READY) begin
                left_d  = left_q - 1'b1;
                state_d = (left_q == CNT_W'(1)) ? FINISH : GEN;
            end
            default: state_d = IDLE;
        endcase
        // ABORT overrides everything, including a START in IDLE and a same-cycle transfer
        if (ABORT) begin
            state_d = IDLE;
            seed_d  = seed_q;
            left_d  = left_q;
            word_d  = word_q;
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            seed_q  <= '0;
            left_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            left_q  <= left_d;
            word_q  <= word_d;
        end
    end
    assign BUSY       = state_q inside {LOAD, GEN, PRESENT};
    assign DONE       = state_q == FINISH;
    assign WORD_VALID = state_q == PRESENT;
    assign LFSR_LOAD  = state_q == LOAD;
    assign LFSR_NEXT  = state_q == GEN;
    assign LFSR_SEED  = seed_q;
    assign WORD_OUT   = word_q;
endmodule
